// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the CPU run-control unit: FSM state encoding and default tick period.
package run_ctrl_pkg;

    typedef logic [1:0] run_state_t;

    localparam run_state_t ST_RUN   = 2'd0;
    localparam run_state_t ST_HALT  = 2'd1;
    localparam run_state_t ST_STEP  = 2'd2;
    localparam run_state_t ST_BREAK = 2'd3;

    localparam int unsigned DEFAULT_LIMIT = 500;

endpackage

// File: rtl/run_ctrl_sync.sv
// Multi-flop synchroniser for an asynchronous level, with an optional one-cycle rising-edge pulse.
module run_ctrl_sync #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_p;
    logic              q_d;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            sync_p <= '0;
            q_d    <= 1'b0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
            q_d    <= sync_p[STAGES-1];
        end
    end

    assign q    = sync_p[STAGES-1];
    assign rise = EDGE_EN ? (q & ~q_d) : 1'b0;

endmodule

// File: rtl/run_control.sv
// CPU run control: tick divider, pause, N-instruction step bursts and a PC breakpoint that is
// compiled in only when RUN_BREAKPOINT_EN is defined.
module run_control #(
    parameter int DIV_W       = 27,
    parameter int STEP_W      = 8,
    parameter int ADDR_W      = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic [DIV_W-1:0]  LIMIT,
    input  logic              PAUSE,
    input  logic              STEP,
    input  logic [STEP_W-1:0] STEP_COUNT,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] BP_ADDR,
    input  logic              BP_VALID,
    output logic              TICK,
    output logic              CPU_EN,
    output logic              HALTED,
    output logic [STEP_W-1:0] STEPS_LEFT,
    output logic              BP_HIT
);

    import run_ctrl_pkg::*;

    logic [DIV_W-1:0]  cnt;
    logic              tick;
    logic              pause_s;
    logic              step_edge;
    logic              unused_step_lvl;
    logic              unused_pause_rise;
    logic              bp_match;
    logic              cpu_en;
    logic [STEP_W-1:0] burst_len;
    run_state_t        state, state_nxt;
    logic [STEP_W-1:0] steps_left, steps_nxt;
    logic              skip, skip_nxt;

    // Wrapping on >= keeps the counter from running away when LIMIT drops below cnt.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N)
            cnt <= '0;
        else if (cnt >= LIMIT)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end

    assign tick = CLR_N && (cnt >= LIMIT);

    run_ctrl_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_step_sync (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .d     (STEP),
        .q     (unused_step_lvl),
        .rise  (step_edge)
    );

    run_ctrl_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_pause_sync (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .d     (PAUSE),
        .q     (pause_s),
        .rise  (unused_pause_rise)
    );

`ifdef RUN_BREAKPOINT_EN
    assign bp_match = BP_VALID && (PC == BP_ADDR) && !skip;
    assign BP_HIT   = (state == ST_BREAK);
`else
    logic unused_bp;
    assign unused_bp = ^{PC, BP_ADDR, BP_VALID};
    assign bp_match  = 1'b0;
    assign BP_HIT    = 1'b0;
`endif

    assign burst_len = (STEP_COUNT == '0) ? STEP_W'(1) : STEP_COUNT;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state      <= ST_RUN;
            steps_left <= '0;
            skip       <= 1'b0;
        end else begin
            state      <= state_nxt;
            steps_left <= steps_nxt;
            skip       <= skip_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        steps_nxt = steps_left;
        skip_nxt  = skip && !cpu_en;
        case (state)
            ST_RUN: begin
                if (pause_s)
                    state_nxt = ST_HALT;
                else if (tick && bp_match)
                    state_nxt = ST_BREAK;
            end
            // Releasing PAUSE outranks a coincident step request.
            ST_HALT: begin
                if (!pause_s) begin
                    state_nxt = ST_RUN;
                end else if (step_edge) begin
                    state_nxt = ST_STEP;
                    steps_nxt = burst_len;
                end
            end
            ST_STEP: begin
                if (tick && bp_match) begin
                    state_nxt = ST_BREAK;
                    steps_nxt = '0;
                end else if (cpu_en) begin
                    steps_nxt = steps_left - STEP_W'(1);
                    if (steps_left == STEP_W'(1))
                        state_nxt = pause_s ? ST_HALT : ST_RUN;
                end
            end
            ST_BREAK: begin
                if (step_edge) begin
                    skip_nxt = 1'b1;
                    if (pause_s) begin
                        state_nxt = ST_STEP;
                        steps_nxt = burst_len;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        cpu_en = 1'b0;
        case (state)
            ST_RUN:  cpu_en = tick && !pause_s && !bp_match;
            ST_STEP: cpu_en = tick && !bp_match;
            default: cpu_en = 1'b0;
        endcase
    end

    assign TICK       = tick;
    assign CPU_EN     = cpu_en;
    assign HALTED     = (state == ST_HALT) || (state == ST_BREAK);
    assign STEPS_LEFT = steps_left;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: divider, pause/step bursts, breakpoint (when RUN_BREAKPOINT_EN) and reset.
module tb_run_control;

    logic        CLK = 1'b0;
    logic        CLR_N;
    logic [26:0] LIMIT;
    logic        PAUSE;
    logic        STEP;
    logic [7:0]  STEP_COUNT;
    logic [13:0] PC;
    logic [13:0] BP_ADDR;
    logic        BP_VALID;
    logic        TICK;
    logic        CPU_EN;
    logic        HALTED;
    logic [7:0]  STEPS_LEFT;
    logic        BP_HIT;

    int tests = 0;
    int fails = 0;

    logic [31:0] tb_bits, en_bits, seq;
    logic [7:0]  maxsl;
    int          en_cnt;

    run_control dut (
        .CLK        (CLK),
        .CLR_N      (CLR_N),
        .LIMIT      (LIMIT),
        .PAUSE      (PAUSE),
        .STEP       (STEP),
        .STEP_COUNT (STEP_COUNT),
        .PC         (PC),
        .BP_ADDR    (BP_ADDR),
        .BP_VALID   (BP_VALID),
        .TICK       (TICK),
        .CPU_EN     (CPU_EN),
        .HALTED     (HALTED),
        .STEPS_LEFT (STEPS_LEFT),
        .BP_HIT     (BP_HIT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit i of each vector holds TICK / CPU_EN at the i-th following falling edge.
    task automatic run_pat(input int n, output logic [31:0] tb_v, output logic [31:0] en_v);
        tb_v = '0;
        en_v = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            tb_v[i] = TICK;
            en_v[i] = CPU_EN;
        end
    endtask

    // Drives STEP from a per-cycle schedule, optionally drops PAUSE, and records the
    // CPU_EN count, the sequence of distinct STEPS_LEFT values (one nibble each) and its maximum.
    task automatic run_step(input int n, input logic [31:0] sched, input int drop_at,
                            output int cnt, output logic [31:0] sq, output logic [7:0] mx);
        logic [7:0] prev;
        prev = STEPS_LEFT;
        cnt  = 0;
        sq   = '0;
        mx   = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            cnt += int'(CPU_EN);
            if (STEPS_LEFT != prev) begin
                sq   = (sq << 4) | {28'd0, STEPS_LEFT[3:0]};
                prev = STEPS_LEFT;
            end
            if (STEPS_LEFT > mx) mx = STEPS_LEFT;
            STEP = sched[i];
            if (i == drop_at) PAUSE = 1'b0;
        end
    endtask

`ifdef RUN_BREAKPOINT_EN
    task automatic pc_run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (CPU_EN) PC = PC + 14'd1;
        end
    endtask
`endif

    initial begin
        CLR_N      = 1'b0;
        LIMIT      = 27'd0;
        PAUSE      = 1'b0;
        STEP       = 1'b0;
        STEP_COUNT = 8'd0;
        PC         = 14'h10;
        BP_ADDR    = 14'h10;
        BP_VALID   = 1'b0;

        repeat (3) @(negedge CLK);
        chk("rst_tick",   32'(TICK), 32'd0);
        chk("rst_cpu_en", 32'(CPU_EN), 32'd0);
        chk("rst_halted", 32'(HALTED), 32'd0);
        chk("rst_steps",  32'(STEPS_LEFT), 32'd0);
        chk("rst_bp_hit", 32'(BP_HIT), 32'd0);

        // Divider period LIMIT+1
        LIMIT = 27'd3;
        CLR_N = 1'b1;
        run_pat(12, tb_bits, en_bits);
        chk("lim3_tick", tb_bits, 32'h444);
        chk("lim3_en",   en_bits, 32'h444);
        LIMIT = 27'd0;
        run_pat(8, tb_bits, en_bits);
        chk("lim0_tick", tb_bits, 32'hFF);
        chk("lim0_en",   en_bits, 32'hFF);

        // LIMIT lowered below the running count
        LIMIT = 27'd9;
        run_pat(7, tb_bits, en_bits);
        chk("lim9_quiet", tb_bits, 32'h0);
        LIMIT = 27'd2;
        #1;
        chk("lower_tick_now", 32'(TICK), 32'd1);
        run_pat(6, tb_bits, en_bits);
        chk("lim2_tick", tb_bits, 32'h24);
        chk("lim2_en",   en_bits, 32'h24);

        // Pause, then a 3-step burst with a second press mid-burst
        PAUSE      = 1'b1;
        STEP_COUNT = 8'd3;
        repeat (4) @(negedge CLK);
        chk("pause_halted", 32'(HALTED), 32'd1);
        run_pat(6, tb_bits, en_bits);
        chk("pause_no_en",   en_bits, 32'h0);
        chk("pause_ticking", 32'($countones(tb_bits)), 32'd2);
        run_step(24, 32'h33, -1, en_cnt, seq, maxsl);
        chk("burst3_count",  32'(en_cnt), 32'd3);
        chk("burst3_seq",    seq, 32'h3210);
        chk("burst3_halted", 32'(HALTED), 32'd1);
        chk("burst3_steps0", 32'(STEPS_LEFT), 32'd0);

        // STEP_COUNT=0 behaves as 1
        STEP_COUNT = 8'd0;
        run_step(16, 32'h3, -1, en_cnt, seq, maxsl);
        chk("burst0_count",  32'(en_cnt), 32'd1);
        chk("burst0_seq",    seq, 32'h10);
        chk("burst0_halted", 32'(HALTED), 32'd1);

        // PAUSE released mid-burst: burst completes, then free run
        STEP_COUNT = 8'd5;
        run_step(24, 32'h3, 4, en_cnt, seq, maxsl);
        chk("burst5_seq",    seq, 32'h543210);
        chk("burst5_run",    32'(HALTED), 32'd0);
        chk("burst5_steps0", 32'(STEPS_LEFT), 32'd0);
        run_pat(9, tb_bits, en_bits);
        chk("burst5_free",   32'($countones(en_bits)), 32'd3);

        // PAUSE release and step edge together: run wins, step discarded
        PAUSE      = 1'b1;
        STEP_COUNT = 8'd3;
        repeat (4) @(negedge CLK);
        chk("simul_halted", 32'(HALTED), 32'd1);
        PAUSE = 1'b0;
        STEP  = 1'b1;
        run_step(12, 32'h3, -1, en_cnt, seq, maxsl);
        chk("simul_no_burst", 32'(maxsl), 32'd0);
        chk("simul_run",      32'(HALTED), 32'd0);

`ifdef RUN_BREAKPOINT_EN
        PC       = 14'h0E;
        BP_VALID = 1'b1;
        pc_run(12);
        chk("bp_hit",    32'(BP_HIT), 32'd1);
        chk("bp_halted", 32'(HALTED), 32'd1);
        chk("bp_pc",     32'(PC), 32'h10);
        STEP = 1'b1;
        pc_run(3);
        STEP = 1'b0;
        pc_run(12);
        chk("bp_resume_clear", 32'(BP_HIT), 32'd0);
        chk("bp_resume_pc",    32'(PC > 14'h11), 32'd1);
        PC = 14'h0F;
        pc_run(12);
        chk("bp_revisit_hit", 32'(BP_HIT), 32'd1);
        chk("bp_revisit_pc",  32'(PC), 32'h10);
        BP_VALID = 1'b0;
        STEP = 1'b1;
        pc_run(3);
        STEP = 1'b0;
        pc_run(3);
`else
        BP_VALID = 1'b1;
        PC       = 14'h10;
        run_pat(9, tb_bits, en_bits);
        chk("nobp_en",  32'($countones(en_bits)), 32'd3);
        chk("nobp_hit", 32'(BP_HIT), 32'd0);
        chk("nobp_run", 32'(HALTED), 32'd0);
        BP_VALID = 1'b0;
`endif

        // Asynchronous reset mid-burst
        PAUSE      = 1'b1;
        STEP_COUNT = 8'd5;
        repeat (4) @(negedge CLK);
        STEP = 1'b1;
        repeat (5) @(negedge CLK);
        chk("rst_mid_burst", 32'(STEPS_LEFT != 8'd0), 32'd1);
        STEP  = 1'b0;
        PAUSE = 1'b0;
        LIMIT = 27'd0;
        CLR_N = 1'b0;
        #1;
        chk("arst_tick",   32'(TICK), 32'd0);
        chk("arst_cpu_en", 32'(CPU_EN), 32'd0);
        chk("arst_halted", 32'(HALTED), 32'd0);
        chk("arst_steps",  32'(STEPS_LEFT), 32'd0);
        chk("arst_bp_hit", 32'(BP_HIT), 32'd0);
        repeat (2) @(negedge CLK);
        chk("arst_hold_tick", 32'(TICK), 32'd0);
        LIMIT = 27'd4;
        CLR_N = 1'b1;
        run_pat(10, tb_bits, en_bits);
        chk("post_rst_tick", tb_bits, 32'h108);
        chk("post_rst_en",   en_bits, 32'h108);
        chk("post_rst_run",  32'(HALTED), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
